// File: rtl/mips_instr_encoder_if.sv
// Field-beat and instruction-memory write bus of mips_instr_encoder.
// The slave modport is the encoder side: it consumes beats and drives the write port.
interface mips_instr_encoder_if #(
  parameter int IM_AW = 10
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_mnem;
  logic [4:0]       in_rs;
  logic [4:0]       in_rt;
  logic [4:0]       in_rd;
  logic [4:0]       in_shamt;
  logic [15:0]      in_imm;
  logic [25:0]      in_target;
  logic             im_we;
  logic [IM_AW-1:0] im_addr;
  logic [31:0]      im_wdata;

  modport slave (
    input  in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
    output in_ready, im_we, im_addr, im_wdata
  );

  modport master (
    output in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
    input  in_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/mips_instr_encoder.sv
// Encodes symbolic MIPS fields into 32-bit words and writes them sequentially into
// instruction memory. Define ENC_ILLEGAL_CHECK_EN to drop illegal codes and raise err.
module mips_instr_encoder #(
  parameter int IM_AW = 10
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [IM_AW-1:0]   i_base_addr,
  input  logic               i_finish,
  mips_instr_encoder_if.slave bus,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_full,
  output logic               o_err,
  output logic [IM_AW:0]     o_word_count
);

  // state   | meaning
  // S_IDLE  | waiting for start after reset
  // S_LOAD  | accepting beats and writing words
  // S_DONE  | load ended (finish or memory full), waiting for start
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [4:0] MN_ADD  = 5'd0;
  localparam logic [4:0] MN_SUB  = 5'd1;
  localparam logic [4:0] MN_AND  = 5'd2;
  localparam logic [4:0] MN_OR   = 5'd3;
  localparam logic [4:0] MN_SLT  = 5'd4;
  localparam logic [4:0] MN_SLTU = 5'd5;
  localparam logic [4:0] MN_ADDU = 5'd6;
  localparam logic [4:0] MN_SUBU = 5'd7;
  localparam logic [4:0] MN_SLL  = 5'd8;
  localparam logic [4:0] MN_NOR  = 5'd9;
  localparam logic [4:0] MN_SRL  = 5'd10;
  localparam logic [4:0] MN_SLLV = 5'd11;
  localparam logic [4:0] MN_SRLV = 5'd12;
  localparam logic [4:0] MN_JR   = 5'd13;
  localparam logic [4:0] MN_JALR = 5'd14;
  localparam logic [4:0] MN_ADDI = 5'd15;
  localparam logic [4:0] MN_ORI  = 5'd16;
  localparam logic [4:0] MN_LW   = 5'd17;
  localparam logic [4:0] MN_SW   = 5'd18;
  localparam logic [4:0] MN_BEQ  = 5'd19;
  localparam logic [4:0] MN_LUI  = 5'd20;
  localparam logic [4:0] MN_SLTI = 5'd21;
  localparam logic [4:0] MN_BNE  = 5'd22;
  localparam logic [4:0] MN_ANDI = 5'd23;
  localparam logic [4:0] MN_J    = 5'd24;
  localparam logic [4:0] MN_JAL  = 5'd25;

  logic [1:0]       r_state;
  logic [IM_AW-1:0] r_next_addr;
  logic [IM_AW:0]   r_word_count;
  logic             r_full;
  logic             r_we;
  logic [IM_AW-1:0] r_addr;
  logic [31:0]      r_wdata;

  logic             w_ready;
  logic             w_accept;
  logic             w_launch;
  logic             w_drop;
  logic             w_last;
  logic [4:0]       w_rs;
  logic [4:0]       w_rt;
  logic [4:0]       w_rd;
  logic [4:0]       w_shamt;
  logic [5:0]       w_funct;
  logic [5:0]       w_op;
  logic [31:0]      w_enc;

  assign w_ready  = (r_state == S_LOAD);
  assign w_accept = bus.in_valid & w_ready;
  assign w_launch = i_start & ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_last   = &r_next_addr;

  always_comb begin
    w_funct = 6'h00;
    case (bus.in_mnem)
      MN_ADD:  w_funct = 6'h20;
      MN_SUB:  w_funct = 6'h22;
      MN_AND:  w_funct = 6'h24;
      MN_OR:   w_funct = 6'h25;
      MN_SLT:  w_funct = 6'h2A;
      MN_SLTU: w_funct = 6'h2B;
      MN_ADDU: w_funct = 6'h21;
      MN_SUBU: w_funct = 6'h23;
      MN_SLL:  w_funct = 6'h00;
      MN_NOR:  w_funct = 6'h27;
      MN_SRL:  w_funct = 6'h02;
      MN_SLLV: w_funct = 6'h04;
      MN_SRLV: w_funct = 6'h06;
      MN_JR:   w_funct = 6'h08;
      MN_JALR: w_funct = 6'h09;
      default: w_funct = 6'h00;
    endcase
  end

  always_comb begin
    w_op = 6'h00;
    case (bus.in_mnem)
      MN_ADDI: w_op = 6'h08;
      MN_ORI:  w_op = 6'h0D;
      MN_LW:   w_op = 6'h23;
      MN_SW:   w_op = 6'h2B;
      MN_BEQ:  w_op = 6'h04;
      MN_LUI:  w_op = 6'h0F;
      MN_SLTI: w_op = 6'h0A;
      MN_BNE:  w_op = 6'h05;
      MN_ANDI: w_op = 6'h0C;
      MN_J:    w_op = 6'h02;
      MN_JAL:  w_op = 6'h03;
      default: w_op = 6'h00;
    endcase
  end

  // Only the constant shifts carry shamt; they ignore rs instead.
  always_comb begin
    w_rs    = bus.in_rs;
    w_rt    = bus.in_rt;
    w_rd    = bus.in_rd;
    w_shamt = 5'd0;
    if ((bus.in_mnem == MN_SLL) || (bus.in_mnem == MN_SRL)) begin
      w_rs    = 5'd0;
      w_shamt = bus.in_shamt;
    end
    if (bus.in_mnem == MN_JR) begin
      w_rt = 5'd0;
      w_rd = 5'd0;
    end
    if (bus.in_mnem == MN_JALR) w_rt = 5'd0;
    if (bus.in_mnem == MN_LUI)  w_rs = 5'd0;
  end

  // Illegal codes fall through to all-zero, which the core executes as a nop.
  always_comb begin
    w_enc = 32'h0000_0000;
    if (bus.in_mnem <= MN_JALR)
      w_enc = {6'h00, w_rs, w_rt, w_rd, w_shamt, w_funct};
    else if (bus.in_mnem <= MN_ANDI)
      w_enc = {w_op, w_rs, w_rt, bus.in_imm};
    else if (bus.in_mnem <= MN_JAL)
      w_enc = {w_op, bus.in_target};
  end

`ifdef ENC_ILLEGAL_CHECK_EN
  logic r_err;
  logic w_illegal;

  assign w_illegal = (bus.in_mnem > MN_JAL);
  assign w_drop    = w_illegal;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_err <= 1'b0;
    else if (w_launch)
      r_err <= 1'b0;
    else if (w_accept && w_illegal)
      r_err <= 1'b1;
  end

  assign o_err = r_err;
`else
  assign w_drop = 1'b0;
  assign o_err  = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_next_addr  <= '0;
      r_word_count <= '0;
      r_full       <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_launch) begin
            r_next_addr  <= i_base_addr;
            r_word_count <= '0;
            r_full       <= 1'b0;
            r_state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_accept && !w_drop) begin
            r_we         <= 1'b1;
            r_addr       <= r_next_addr;
            r_wdata      <= w_enc;
            r_next_addr  <= r_next_addr + IM_AW'(1);
            r_word_count <= r_word_count + (IM_AW+1)'(1);
            // Top of memory: stop rather than wrap onto the start of the program.
            if (w_last) begin
              r_full  <= 1'b1;
              r_state <= S_DONE;
            end
          end
          if (i_finish) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.im_we     = r_we;
  assign bus.im_addr   = r_addr;
  assign bus.im_wdata  = r_wdata;
  assign o_busy        = (r_state == S_LOAD);
  assign o_done        = (r_state == S_DONE);
  assign o_full        = r_full;
  assign o_word_count  = r_word_count;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder: directed scenarios plus randomized beats
// compared against a table-driven encoding model.
module tb_mips_instr_encoder;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          finish;
  logic [AW-1:0] base;
  logic          busy, done, full, err;
  logic [AW:0]   wc;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mips_instr_encoder_if #(.IM_AW(AW)) ifc ();

  mips_instr_encoder #(.IM_AW(AW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_base_addr (base),
    .i_finish    (finish),
    .bus         (ifc),
    .o_busy      (busy),
    .o_done      (done),
    .o_full      (full),
    .o_err       (err),
    .o_word_count(wc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
    int            c;
  } wr_t;

  wr_t got_q[$];
  wr_t exp_q[$];

  always @(negedge clk)
    if (ifc.im_we === 1'b1) got_q.push_back('{ifc.im_addr, ifc.im_wdata, cyc});

  localparam logic [5:0] R_FUNCT [15] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h2B, 6'h21, 6'h23,
                                          6'h00, 6'h27, 6'h02, 6'h04, 6'h06, 6'h08, 6'h09};
  localparam logic [5:0] I_OP [9] = '{6'h08, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h0F, 6'h0A, 6'h05, 6'h0C};

  logic [AW-1:0] m_addr;
  int            m_cnt;
  bit            m_err, m_full;

  function automatic logic [31:0] ref_encode(input int m, input logic [4:0] rs, rt, rd, sh,
                                             input logic [15:0] imm, input logic [25:0] tg);
    if (m <= 14) begin
      if (m == 8 || m == 10) rs = 5'd0;
      else sh = 5'd0;
      if (m == 13) begin rt = 5'd0; rd = 5'd0; end
      if (m == 14) rt = 5'd0;
      return {6'd0, rs, rt, rd, sh, R_FUNCT[m]};
    end else if (m <= 23) begin
      if (m == 20) rs = 5'd0;
      return {I_OP[m-15], rs, rt, imm};
    end else if (m <= 25) begin
      return {(m == 24) ? 6'h02 : 6'h03, tg};
    end
    return 32'h0;
  endfunction

  task automatic model_start(input logic [AW-1:0] b);
    m_addr = b; m_cnt = 0; m_err = 0; m_full = 0;
    exp_q.delete();
  endtask

  task automatic model_accept(input int m, input logic [4:0] rs, rt, rd, sh,
                              input logic [15:0] imm, input logic [25:0] tg);
`ifdef ENC_ILLEGAL_CHECK_EN
    if (m >= 26) begin m_err = 1; return; end
`endif
    exp_q.push_back('{m_addr, ref_encode(m, rs, rt, rd, sh, imm, tg), 0});
    m_cnt++;
    if (m_addr == {AW{1'b1}}) m_full = 1;
    m_addr = m_addr + 1'b1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [AW-1:0] b);
    base = b; start = 1'b1;
    tick();
    start = 1'b0;
    model_start(b);
  endtask

  task automatic do_finish();
    ifc.in_valid = 1'b0; finish = 1'b1;
    tick();
    finish = 1'b0;
  endtask

  task automatic set_beat(input int m, input logic [4:0] rs, rt, rd, sh,
                          input logic [15:0] imm, input logic [25:0] tg);
    ifc.in_valid = 1'b1; ifc.in_mnem = 5'(m);
    ifc.in_rs = rs; ifc.in_rt = rt; ifc.in_rd = rd; ifc.in_shamt = sh;
    ifc.in_imm = imm; ifc.in_target = tg;
  endtask

  // Holds the beat until the edge that accepts it; leaves in_valid high for back-to-back use.
  task automatic send(input int m, input logic [4:0] rs, rt, rd, sh,
                      input logic [15:0] imm, input logic [25:0] tg);
    bit ok = 0;
    set_beat(m, rs, rt, rd, sh, imm, tg);
    for (int i = 0; i < 20; i++) begin
      bit rdy;
      rdy = ifc.in_ready;
      tick();
      if (rdy) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout mnem=%0d got no in_ready want accepted", m);
    end else begin
      model_accept(m, rs, rt, rd, sh, imm, tg);
    end
  endtask

  task automatic send_random(input int mmax);
    send($urandom_range(0, mmax), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
         16'($urandom), 26'($urandom));
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; finish = 1'b0; base = 10'h155;
    ifc.in_valid = 1'b1; ifc.in_mnem = 5'd0;
    ifc.in_rs = 0; ifc.in_rt = 0; ifc.in_rd = 0; ifc.in_shamt = 0; ifc.in_imm = 0; ifc.in_target = 0;
    repeat (3) tick();
    checks++;
    if ({busy, done, full, err, wc} !== '0) begin
      errors++;
      $display("FAIL reset_status got busy=%b done=%b full=%b err=%b wc=%0d want all 0", busy, done, full, err, wc);
    end
    checks++;
    if ({ifc.im_we, ifc.im_addr, ifc.im_wdata, ifc.in_ready} !== '0) begin
      errors++;
      $display("FAIL reset_bus got we=%b addr=%h data=%h rdy=%b want all 0",
               ifc.im_we, ifc.im_addr, ifc.im_wdata, ifc.in_ready);
    end
    rst = 1'b0; start = 1'b0; ifc.in_valid = 1'b0;
    tick();
    checks++;
    if (ifc.in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready got rdy=%b busy=%b want 0 0", ifc.in_ready, busy);
    end
  endtask

  task automatic test_basic();
    got_q.delete();
    do_start(10'h010);
    checks++;
    if (busy !== 1'b1 || ifc.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_busy got busy=%b rdy=%b want 1 1", busy, ifc.in_ready);
    end
    send(0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    send(15, 5'd0, 5'd5, 5'd0, 5'd0, 16'hFFFF, 26'h0);
    do_finish();
    tick();
    checks++;
    if (got_q.size() != 2) begin
      errors++;
      $display("FAIL basic_count got %0d writes want 2", got_q.size());
    end else begin
      checks++;
      if (got_q[0].a !== 10'h010 || got_q[0].d !== 32'h0022_1820) begin
        errors++;
        $display("FAIL basic_add got %h:%h want 010:00221820", got_q[0].a, got_q[0].d);
      end
      checks++;
      if (got_q[1].a !== 10'h011 || got_q[1].d !== 32'h2005_FFFF) begin
        errors++;
        $display("FAIL basic_addi got %h:%h want 011:2005ffff", got_q[1].a, got_q[1].d);
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || wc !== 11'd2 || ifc.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_done got done=%b busy=%b wc=%0d rdy=%b want 1 0 2 0", done, busy, wc, ifc.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int acc_cyc;
    got_q.delete();
    do_start(10'h100);
    send(24, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h000_0040);
    acc_cyc = cyc;
    send(25, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FF_FFFF);
    send(17, 5'd29, 5'd31, 5'd0, 5'd0, 16'h0004, 26'h0);
    ifc.in_valid = 1'b0;
    tick();
    checks++;
    if (got_q.size() != 3) begin
      errors++;
      $display("FAIL b2b_count got %0d writes want 3", got_q.size());
    end else begin
      checks++;
      if (got_q[0].d !== 32'h0800_0040 || got_q[1].d !== 32'h0FFF_FFFF || got_q[2].d !== 32'h8FBF_0004) begin
        errors++;
        $display("FAIL b2b_data got %h %h %h want 08000040 0fffffff 8fbf0004", got_q[0].d, got_q[1].d, got_q[2].d);
      end
      checks++;
      if (got_q[0].a !== 10'h100 || got_q[1].a !== 10'h101 || got_q[2].a !== 10'h102) begin
        errors++;
        $display("FAIL b2b_addr got %h %h %h want 100 101 102", got_q[0].a, got_q[1].a, got_q[2].a);
      end
      checks++;
      if (got_q[0].c != acc_cyc || got_q[1].c != acc_cyc + 1 || got_q[2].c != acc_cyc + 2) begin
        errors++;
        $display("FAIL b2b_timing got cycles %0d %0d %0d want %0d..%0d", got_q[0].c, got_q[1].c, got_q[2].c,
                 acc_cyc, acc_cyc + 2);
      end
    end
    do_finish();
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      got_q.delete();
      do_start(10'($urandom_range(0, 10'h300)));
      for (int b = 0; b < 40; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          ifc.in_valid = 1'b0;
          tick();
        end
        send_random(31);
      end
      do_finish();
      tick();
      checks++;
      if (got_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL rand_count round=%0d got %0d writes want %0d", r, got_q.size(), exp_q.size());
      end else begin
        for (int i = 0; i < got_q.size(); i++) begin
          checks++;
          if (got_q[i].a !== exp_q[i].a || got_q[i].d !== exp_q[i].d) begin
            errors++;
            $display("FAIL rand_word round=%0d idx=%0d got %h:%h want %h:%h", r, i,
                     got_q[i].a, got_q[i].d, exp_q[i].a, exp_q[i].d);
          end
        end
      end
      checks++;
      if (wc !== 11'(m_cnt) || err !== m_err || done !== 1'b1 || full !== 1'b0) begin
        errors++;
        $display("FAIL rand_status round=%0d got wc=%0d err=%b done=%b full=%b want %0d %b 1 0",
                 r, wc, err, done, full, m_cnt, m_err);
      end
    end
  endtask

  task automatic test_full();
    bit seen_ready = 0;
    got_q.delete();
    do_start(10'h3FE);
    send_random(25);
    send_random(25);
    checks++;
    if (full !== 1'b1 || done !== 1'b1 || ifc.in_ready !== 1'b0 || !m_full) begin
      errors++;
      $display("FAIL full_flags got full=%b done=%b rdy=%b want 1 1 0", full, done, ifc.in_ready);
    end
    set_beat(0, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0);
    repeat (5) begin
      if (ifc.in_ready) seen_ready = 1;
      tick();
    end
    ifc.in_valid = 1'b0;
    checks++;
    if (seen_ready) begin
      errors++;
      $display("FAIL full_third_beat got in_ready=1 want 0");
    end
    checks++;
    if (got_q.size() != 2 || wc !== 11'd2) begin
      errors++;
      $display("FAIL full_count got %0d writes wc=%0d want 2 2", got_q.size(), wc);
    end else begin
      checks++;
      if (got_q[0].a !== 10'h3FE || got_q[1].a !== 10'h3FF ||
          got_q[0].d !== exp_q[0].d || got_q[1].d !== exp_q[1].d) begin
        errors++;
        $display("FAIL full_words got %h:%h %h:%h want 3fe:%h 3ff:%h", got_q[0].a, got_q[0].d,
                 got_q[1].a, got_q[1].d, exp_q[0].d, exp_q[1].d);
      end
    end
  endtask

  task automatic test_illegal();
    got_q.delete();
    do_start(10'h020);
    send(30, 5'd7, 5'd8, 5'd9, 5'd3, 16'h1234, 26'h0);
    send(0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    ifc.in_valid = 1'b0;
    tick();
`ifdef ENC_ILLEGAL_CHECK_EN
    checks++;
    if (got_q.size() != 1 || err !== 1'b1 || wc !== 11'd1) begin
      errors++;
      $display("FAIL illegal_drop got %0d writes err=%b wc=%0d want 1 1 1", got_q.size(), err, wc);
    end else begin
      checks++;
      if (got_q[0].a !== 10'h020 || got_q[0].d !== 32'h0022_1820) begin
        errors++;
        $display("FAIL illegal_next got %h:%h want 020:00221820", got_q[0].a, got_q[0].d);
      end
    end
`else
    checks++;
    if (got_q.size() != 2 || err !== 1'b0 || wc !== 11'd2) begin
      errors++;
      $display("FAIL illegal_nop got %0d writes err=%b wc=%0d want 2 0 2", got_q.size(), err, wc);
    end else begin
      checks++;
      if (got_q[0].a !== 10'h020 || got_q[0].d !== 32'h0 || got_q[1].a !== 10'h021) begin
        errors++;
        $display("FAIL illegal_word got %h:%h next %h want 020:00000000 next 021",
                 got_q[0].a, got_q[0].d, got_q[1].a);
      end
    end
`endif
    do_finish();
    do_start(10'h030);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got err=%b want 0", err);
    end
    do_finish();
  endtask

  task automatic test_reset_mid();
    do_start(10'h040);
    send(3, 5'd3, 5'd1, 5'd2, 5'd0, 16'h0, 26'h0);
    checks++;
    if (ifc.im_we !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre_write got im_we=%b want 1", ifc.im_we);
    end
    ifc.in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, done, full, err, wc, ifc.im_we, ifc.im_addr, ifc.im_wdata, ifc.in_ready} !== '0) begin
      errors++;
      $display("FAIL mid_reset got busy=%b done=%b wc=%0d we=%b addr=%h data=%h want all 0",
               busy, done, wc, ifc.im_we, ifc.im_addr, ifc.im_wdata);
    end
    got_q.delete();
    tick();
    checks++;
    if (got_q.size() != 0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_idle got %0d writes busy=%b done=%b want 0 0 0", got_q.size(), busy, done);
    end
    do_start(10'h050);
    send(6, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0);
    do_finish();
    checks++;
    if (got_q.size() != 1 || got_q[0].a !== 10'h050 || got_q[0].d !== 32'h0085_3021 || wc !== 11'd1) begin
      errors++;
      $display("FAIL mid_restart got %0d writes wc=%0d want one 050:00853021 wc=1", got_q.size(), wc);
    end
  endtask

  task automatic test_finish_same_edge();
    bit ok = 0;
    got_q.delete();
    do_start(10'h060);
    set_beat(8, 5'd7, 5'd4, 5'd4, 5'd2, 16'h0, 26'h0);
    finish = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bit rdy;
      rdy = ifc.in_ready;
      tick();
      if (rdy) begin ok = 1; break; end
    end
    finish = 1'b0; ifc.in_valid = 1'b0;
    checks++;
    if (!ok || ifc.im_we !== 1'b1 || ifc.im_addr !== 10'h060 || ifc.im_wdata !== 32'h0004_2080) begin
      errors++;
      $display("FAIL finish_write got we=%b %h:%h want 1 060:00042080", ifc.im_we, ifc.im_addr, ifc.im_wdata);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || wc !== 11'd1) begin
      errors++;
      $display("FAIL finish_done got done=%b busy=%b wc=%0d want 1 0 1", done, busy, wc);
    end
    tick();
    checks++;
    if (ifc.im_we !== 1'b0 || ifc.im_wdata !== 32'h0004_2080 || done !== 1'b1) begin
      errors++;
      $display("FAIL done_hold got we=%b data=%h done=%b want 0 00042080 1", ifc.im_we, ifc.im_wdata, done);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_random();
    test_full();
    test_illegal();
    test_reset_mid();
    test_finish_same_edge();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_instr_encoder.md
# mips_instr_encoder

Instruction encoder and program loader for the single-cycle MIPS core: the inverse of the control decoder. It accepts symbolic instruction fields (a mnemonic code plus register, shift, immediate and jump-target fields) over a valid/ready handshake. Each accepted beat is encoded into a 32-bit MIPS word in the Op/Funct layout the core's decoder expects, then written sequentially into instruction memory from a programmable base address. Test benches and the boot path use it to load programs without a pre-assembled hex file.

## Interface
- IM_AW, 10, instruction-memory word-address width; capacity 2^IM_AW words
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  pulse; in IDLE or DONE, latches base_addr and begins a load
- base_addr  in  IM_AW  first word address of the load
- finish  in  1  pulse; ends the load
- in_valid  in  1  field beat valid
- in_ready  out  1  encoder accepts beat (high only in LOAD)
- in_mnem  in  5  mnemonic code (see Operation)
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register / shift fields
- in_imm  in  16  immediate / branch offset
- in_target  in  26  jump target
- im_we  out  1  instruction-memory write strobe
- im_addr  out  IM_AW  write word address
- im_wdata  out  32  encoded instruction word
- busy  out  1  state is LOAD
- done  out  1  state is DONE
- full  out  1  load stopped because the last address was written
- err  out  1  sticky illegal-mnemonic flag (see Configuration)
- word_count  out  IM_AW+1  words written since start

## Operation
- FSM states: IDLE, LOAD, DONE. Reset state is IDLE.
- IDLE/DONE + start: next_addr <= base_addr, word_count <= 0, full <= 0, err <= 0, go LOAD. start in LOAD is ignored.
- LOAD: beat accepted when in_valid & in_ready. The encoded word is registered onto im_wdata, with im_addr <= next_addr and im_we <= 1 for one cycle. next_addr and word_count then increment.
- Codes 0-14 are R-type, encoded as {6'h00, rs, rt, rd, shamt, funct}:
  - add 20h, sub 22h, and 24h, or 25h, slt 2Ah, sltu 2Bh, addu 21h, subu 23h, sll 00h, nor 27h, srl 02h, sllv 04h, srlv 06h, jr 08h, jalr 09h.
  - sll/srl force rs=0.
  - All other R-type codes force shamt=0.
  - jr forces rt=rd=0; jalr forces rt=0.
- Codes 15-23 are I-type, encoded as {op, rs, rt, imm}:
  - addi 08h, ori 0Dh, lw 23h, sw 2Bh, beq 04h, lui 0Fh, slti 0Ah, bne 05h, andi 0Ch.
  - lui forces rs=0.
- Codes 24-25 are J-type, encoded as {op, target}: j 02h, jal 03h.
- Codes 26-31 are illegal; handling is set by Configuration.
- Accepted beat at next_addr = 2^IM_AW-1: the word is written, full <= 1, go DONE. No wrap-around.
- finish in LOAD: go DONE. If a beat is accepted on the same edge, it is written first.
- DONE holds all outputs except im_we (0) until start.
- rst at any time: IDLE, and every output goes to 0 (im_addr, im_wdata, word_count included). A write registered but not yet emitted is dropped.

## Timing
- Latency is one cycle: a beat accepted at edge N drives im_we/im_addr/im_wdata during cycle N+1.
- Back-to-back beats give one write per cycle at consecutive addresses.
- in_ready is combinational from state only (not from in_valid).
- in_ready is low from the edge that enters DONE, including the full and finish cases.
- busy/done/full/err/word_count are registered; they update on the edge that accepts the triggering event.

## Configuration
- ENC_ILLEGAL_CHECK_EN defined: an illegal code is accepted (handshake completes) but produces no write. next_addr and word_count do not advance, and err is set sticky until the next start.
- ENC_ILLEGAL_CHECK_EN undefined: an illegal code encodes as 32'h0000_0000 (sll $0,$0,0 = nop) and is written normally. err is tied to 0.

## Test plan
- start base=0x010, beats add rs=1 rt=2 rd=3, then addi rs=0 rt=5 imm=0xFFFF, then finish -> writes 0x010:0x00221820, 0x011:0x2005FFFF; done=1; word_count=2.
- j target=0x0000040, then jal target=0x3FFFFFF, then lw rs=29 rt=31 imm=4, continuous in_valid -> writes on three consecutive cycles: 0x08000040, 0x0FFFFFFF, 0x8FBF0004.
- IM_AW=4, start base=0xE, three beats -> two writes (0xE, 0xF), then full=1 and done=1. Third beat not accepted (in_ready=0).
- Illegal code 30 with ENC_ILLEGAL_CHECK_EN -> no im_we, err=1, address unchanged. Without the macro -> writes 0x00000000 and err=0.
- rst asserted the cycle after an accepted beat -> no im_we in the following cycle; all outputs 0; state IDLE; a subsequent start works normally.
- finish on the same edge as an accepted sll rt=4 rd=4 shamt=2 -> write 0x00042080 emitted, done=1 next cycle.
